// File: rtl/btn_cond_pkg.sv
// Shared constants for the button conditioner.
// Register map and debounce counter sizing.
package btn_cond_pkg;

  localparam logic ADDR_LEVEL = 1'b0;
  localparam logic ADDR_EVENT = 1'b1;

  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_cond_channel.sv
// One conditioning lane: synchroniser,
// debouncer and edge detector for one input.
module btn_cond_channel
  import btn_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_stable;
  logic                   r_prev;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

  // A new level must persist DB_CYCLES cycles before it is accepted
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (w_s == r_stable) begin
      r_cnt    <= '0;
    end else if (r_cnt == CMAX) begin
      r_stable <= w_s;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= r_stable;
    end
  end

  assign o_level = r_stable;
  assign o_rise  = r_stable & ~r_prev;
  assign o_fall  = ~r_stable & r_prev;

endmodule

// File: rtl/module_btn_conditioner.sv
// N-channel button conditioner with sticky
// rise-event flags on a small bus slave.
module module_btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int N_CH        = 5,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 100000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  input  logic            we_i,
  input  logic            addr_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o,
  output logic            irq_o
);

  logic [N_CH-1:0] r_event;
  logic [N_CH-1:0] w_clr;
  logic            w_unused_wdata;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_cond_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES  (DB_CYCLES)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .i_btn  (btn_i[g]),
      .o_level(level_o[g]),
      .o_rise (rise_o[g]),
      .o_fall (fall_o[g])
    );
  end

  assign w_unused_wdata = ^wdata_i;

  assign w_clr = (we_i && addr_i == ADDR_EVENT)
               ? wdata_i[N_CH-1:0] : '0;

  // A rise in the same cycle as its clear keeps the flag set
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_event <= '0;
    end else begin
      r_event <= (r_event & ~w_clr) | rise_o;
    end
  end

  assign rdata_o = (addr_i == ADDR_EVENT)
                 ? 32'(r_event) : 32'(level_o);
  assign irq_o   = |r_event;

endmodule

// File: tb/tb_module_btn_conditioner.sv
// Randomised + directed bench for the button
// conditioner, scoreboard against a window model.
module tb_module_btn_conditioner;

  localparam int N    = 5;
  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic [N-1:0]  btn_i = '1;
  logic [N-1:0]  level_o, rise_o, fall_o;
  logic          we_i = 1'b0;
  logic          addr_i = 1'b0;
  logic [31:0]   wdata_i = '0;
  logic [31:0]   rdata_o;
  logic          irq_o;

  int n_vec  = 0;
  int n_miss = 0;

  module_btn_conditioner #(
    .N_CH(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .btn_i(btn_i),
    .level_o(level_o), .rise_o(rise_o), .fall_o(fall_o),
    .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [N-1:0] lv;
    logic [N-1:0] ri;
    logic [N-1:0] fa;
    logic [N-1:0] ev;
  } exp_t;

  exp_t         sbq[$];
  logic [N-1:0] hq[$];
  logic [N-1:0] wq[$];
  logic [N-1:0] m_st, m_prev, m_ev, m_d, m_clr, m_drop;
  bit           m_held;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    hq.delete();
    for (int i = 0; i < SYNC; i++) hq.push_back('0);
    wq.delete();
    sbq.delete();
    m_st = '0; m_prev = '0; m_ev = '0;
  endtask

  // Level flips once the last DB synchronised samples all disagree with it
  initial begin
    m_reset();
    forever begin
      @(posedge clk_i or negedge rst_i);
      if (!rst_i) begin
        m_reset();
      end else begin
        exp_t e;
        hq.push_back(btn_i);
        m_d = hq.pop_front();
        wq.push_back(m_d);
        if (wq.size() > DB) m_drop = wq.pop_front();
        m_clr  = (we_i && addr_i) ? wdata_i[N-1:0] : '0;
        m_ev   = (m_ev & ~m_clr) | (m_st & ~m_prev);
        m_prev = m_st;
        if (wq.size() == DB) begin
          for (int k = 0; k < N; k++) begin
            m_held = 1'b1;
            foreach (wq[j]) if (wq[j][k] == m_st[k]) m_held = 1'b0;
            if (m_held) m_st[k] = ~m_st[k];
          end
        end
        e.lv = m_st;
        e.ri = m_st & ~m_prev;
        e.fa = ~m_st & m_prev;
        e.ev = m_ev;
        sbq.push_back(e);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        chk("reset_outs",
            {level_o, rise_o, fall_o, irq_o, rdata_o[11:0]}, '0);
      end else if (sbq.size() > 0) begin
        exp_t e;
        logic [N-1:0] rd;
        e  = sbq.pop_front();
        rd = addr_i ? e.ev : e.lv;
        chk("scoreboard",
            {level_o, rise_o, fall_o, irq_o, rdata_o[11:0]},
            {e.lv, e.ri, e.fa, |e.ev, 7'b0, rd});
        chk("rdata_hi", {20'b0, rdata_o[31:N]}, '0);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    we_i = 1'b1; addr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0; wdata_i = '0;
  endtask

  task automatic rd_ev(input string nm, input logic [31:0] exp);
    addr_i = 1'b1;
    #1 chk(nm, rdata_o, exp);
  endtask

  initial begin
    // reset with all buttons held high
    repeat (3) tick();
    chk("lvl_in_reset", 32'(level_o), 32'h0);
    rst_i = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 5) chk("t1_lvl_e5", 32'(level_o), 32'h0);
      if (i == 6) chk("t1_lvl_e6", 32'(level_o), 32'h1F);
      if (i == 6) chk("t1_rise", 32'(rise_o), 32'h1F);
      if (i == 7) chk("t1_rise_gone", 32'(rise_o), 32'h0);
    end
    rd_ev("t1_event", 32'h1F);
    btn_i = '0;
    repeat (8) tick();
    wr(1'b1, 32'hFFFF_FFFF);
    rd_ev("t1_cleared", 32'h0);

    // glitch rejection on channel 2
    for (int r = 0; r < 10; r++) begin
      btn_i[2] = 1'b1;
      repeat (3) tick();
      btn_i[2] = 1'b0;
      repeat (2) tick();
    end
    repeat (6) tick();
    chk("t2_level", 32'(level_o), 32'h0);
    rd_ev("t2_event", 32'h0);

    // clean press and release on channel 0
    btn_i[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 5) chk("t3_lvl_e5", 32'(level_o[0]), 32'h0);
      if (i == 6) chk("t3_rise", 32'({level_o[0], rise_o[0], irq_o}), 32'h6);
      if (i == 7) chk("t3_irq", 32'({rise_o[0], irq_o}), 32'h1);
    end
    rd_ev("t3_event", 32'h1);
    btn_i[0] = 1'b0;
    repeat (6) tick();
    chk("t3_fall", 32'({level_o[0], fall_o[0]}), 32'h1);
    rd_ev("t3_event_kept", 32'h1);

    // write-1-to-clear
    btn_i = 5'b10100;
    repeat (8) tick();
    btn_i = '0;
    repeat (8) tick();
    rd_ev("t4_pre", 32'h15);
    wr(1'b1, 32'h0000_0005);
    rd_ev("t4_part", 32'h10);
    chk("t4_irq1", 32'(irq_o), 32'h1);
    wr(1'b1, 32'hFFFF_FFFF);
    rd_ev("t4_all", 32'h0);
    chk("t4_irq0", 32'(irq_o), 32'h0);
    btn_i[1] = 1'b1;
    repeat (8) tick();
    btn_i[1] = 1'b0;
    repeat (8) tick();
    wr(1'b0, 32'hFFFF_FFFF);
    rd_ev("t4_level_wr", 32'h2);
    wr(1'b1, 32'hFFFF_FFFF);

    // clear collides with the rise on channel 3
    btn_i[3] = 1'b1;
    repeat (6) tick();
    chk("t5_rise", 32'(rise_o[3]), 32'h1);
    wr(1'b1, 32'h0000_0008);
    rd_ev("t5_kept", 32'h8);

    // asynchronous reset mid-count on channel 1
    btn_i[1] = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    #1 chk("t6_zero",
           {level_o, rise_o, fall_o, irq_o, rdata_o[11:0]}, '0);
    repeat (2) tick();
    rst_i = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 5) chk("t6_lvl_e5", 32'(level_o), 32'h0);
      if (i == 6) chk("t6_lvl_e6", 32'(level_o), 32'h0A);
    end
    rd_ev("t6_event", 32'h0A);

    // randomised bouncing, holds and bus traffic
    for (int s = 0; s < 60; s++) begin
      int lim;
      lim = ($urandom_range(0, 1) != 0) ? 3 : 40;
      for (int c = 0; c < 50; c++) begin
        for (int k = 0; k < N; k++)
          if ($urandom_range(0, lim - 1) == 0) btn_i[k] = ~btn_i[k];
        addr_i = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 7) == 0) wr(addr_i, $urandom);
        else tick();
      end
    end
    btn_i = '0;
    repeat (20) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/module_btn_conditioner.md
# module_btn_conditioner

Parametrised input-conditioning block for the push-buttons and reset button of the single-cycle RISC-V SoC, replacing per-button instances of separate debouncer and synchroniser modules with one N-channel block. Each channel synchronises, debounces and edge-detects one raw input. Sticky rise-event flags, plus the debounced levels, are readable through a small bus slave on the data bus, with write-1-to-clear on the event flags. An `irq_o` output summarises pending events for a future interrupt or polling path.

## Interface
- `N_CH`, default 5: number of input channels, 1..32.
- `SYNC_STAGES`, default 2: synchroniser flip-flop depth, ≥2.
- `DB_CYCLES`, default 100000: consecutive cycles a new level must persist to be accepted (10 ms at 10 MHz), ≥2.

Ports:
- `clk_i`  in  1  system clock (10 MHz clocking-wizard output).
- `rst_i`  in  1  asynchronous, active-low reset.
- `btn_i`  in  N_CH  raw, asynchronous, bouncing inputs.
- `level_o`  out  N_CH  debounced levels.
- `rise_o`  out  N_CH  one-cycle pulse on each debounced 0→1.
- `fall_o`  out  N_CH  one-cycle pulse on each debounced 1→0.
- `we_i`  in  1  bus write strobe, already decoded for this block.
- `addr_i`  in  1  register select: 0 = LEVEL (read-only), 1 = EVENT (read / W1C).
- `wdata_i`  in  32  bus write data.
- `rdata_o`  out  32  bus read data.
- `irq_o`  out  1  OR of all EVENT bits.

## Operation
- Per channel pipeline: synchroniser → debouncer → edge detector.
- **Synchroniser:** `SYNC_STAGES` flip-flops; the last stage output is `s`.
- **Debouncer:**
  - State is the `stable` bit and a counter of width `$clog2(DB_CYCLES)`.
  - If `s == stable`: counter ← 0.
  - Else if counter == `DB_CYCLES-1`: `stable` ← `s` and counter ← 0.
  - Else: counter ← counter+1.
  - A mismatch shorter than `DB_CYCLES` consecutive cycles never changes `stable`. The counter never exceeds `DB_CYCLES-1`.
- **Edge detector:**
  - `prev` is a register holding `stable` delayed one cycle.
  - `rise_o` = `stable & ~prev`; `fall_o` = `~stable & prev`.
  - `level_o` = `stable`.
- **EVENT register** (N_CH bits), per bit k, evaluated each cycle:
  - bit set if `rise_o[k]`;
  - otherwise bit cleared if `we_i && addr_i==1 && wdata_i[k]`;
  - otherwise bit holds.
  - Set wins over a simultaneous clear.
- **Writes:** to LEVEL are ignored. `wdata_i` bits ≥ N_CH are ignored.
- **Read data** (combinational from registers):
  - `addr_i==0` → LEVEL, zero-extended to 32 bits.
  - `addr_i==1` → EVENT, zero-extended to 32 bits.
- `irq_o` = `|EVENT`, driven combinationally from the register.

## Timing
- **Reset:** clears the sync chain, `stable`, `prev`, counters and EVENT. After reset: `level_o`=0, `rise_o`=0, `fall_o`=0, `irq_o`=0, `rdata_o`=0 for both addresses.
- **Latency:** if `btn_i[k]` changes before clock edge E1 and then holds, `level_o[k]` changes right after edge E(`SYNC_STAGES`+`DB_CYCLES`).
  - `rise_o`/`fall_o` are high for exactly the first cycle of the new level.
  - The EVENT bit reads 1 from the following edge onward; `irq_o` rises in that same cycle.
- **Reset mid-operation:** partially counted bounces are discarded. An input held high through reset release produces a full-latency rise and an event after release.
- **Bouncing:** toggling with period < `DB_CYCLES` keeps the counter resetting or restarting; level, pulses and EVENT are unchanged.
- **Channel independence:** channels are fully independent; simultaneous events on several channels all set their bits in the same cycle.

## Structure
- **Package `btn_cond_pkg`:**
  - localparams `ADDR_LEVEL`=1'b0 and `ADDR_EVENT`=1'b1;
  - a function returning the counter width (`$clog2`, minimum 1).
- **Sub-module `btn_cond_channel`:** synchroniser, debouncer and edge detector for one bit, instantiated N_CH times in a generate loop.
- **Top level:** owns the EVENT register, bus read mux and `irq_o`.

## Test plan
Benches use `N_CH`=5, `SYNC_STAGES`=2, `DB_CYCLES`=4.
1. **Reset:** assert `rst_i`=0 with all `btn_i`=1, then release → `level_o`=0 during reset; `level_o`=5'h1F exactly 6 edges after release; one `rise_o`=5'h1F pulse; EVENT reads 32'h1F.
2. **Glitch rejection:** `btn_i[2]` pulses high for 3 cycles, repeated 10 times → `level_o`, `rise_o` and EVENT stay 0.
3. **Clean press:** `btn_i[0]` 0→1 and held → `level_o[0]` rises after edge 6; `rise_o[0]` high for 1 cycle; `irq_o`=1 the next cycle; read at addr 1 = 32'h1. Release → `fall_o[0]` pulse; EVENT unchanged.
4. **W1C:** with EVENT=5'b10101, write 32'h0000_0005 to addr 1 → EVENT=5'b10000, `irq_o` stays 1. Write 32'hFFFF_FFFF → EVENT=0, `irq_o`=0. Write to addr 0 → no effect.
5. **Set/clear collision:** W1C of bit 3 in the same cycle as `rise_o[3]` → bit 3 remains 1.
6. **Mid-operation reset:** `btn_i[1]` high, reset asserted asynchronously after 3 sync+debounce cycles → all outputs 0 immediately. After release, `level_o[1]` rises at the full 6-edge latency.
